// File: rtl/types_pnp_pkg.sv
// types_pnp_pkg: plug-and-play descriptor types shared by the pnp slave,
// the interconnect decoder and the address lookup engine.
//   dev_config_type : one descriptor (type, address window, VID, DID)
//   soc_pnp_vector  : the full descriptor vector, SOC_PNP_TOTAL entries
//   pnp_addr_match  : range/type/DID match rule for one descriptor
package types_pnp_pkg;

  localparam int SOC_PNP_TOTAL    = 16;
  localparam int SOC_PNP_IDX_BITS = $clog2(SOC_PNP_TOTAL);

  typedef enum logic [1:0] {
    PNP_CFG_TYPE_INVALID = 2'b00,
    PNP_CFG_TYPE_MASTER  = 2'b01,
    PNP_CFG_TYPE_SLAVE   = 2'b10
  } pnp_cfg_type_e;

  // DID value marking an unpopulated slave slot.
  localparam logic [15:0] SLV_DID_EMPTY = 16'h5577;

  typedef struct packed {
    pnp_cfg_type_e descrtype;
    logic [63:0]   addr_start;  // inclusive
    logic [63:0]   addr_end;    // exclusive
    logic [15:0]   vid;
    logic [15:0]   did;
  } dev_config_type;

  typedef dev_config_type [SOC_PNP_TOTAL-1:0] soc_pnp_vector;

  // A populated slave whose window [start, end) contains addr. A window
  // with end <= start can never satisfy both compares, so it never matches.
  function automatic logic pnp_addr_match(dev_config_type cfg, logic [63:0] addr);
    return (cfg.descrtype == PNP_CFG_TYPE_SLAVE) &&
           (cfg.did != SLV_DID_EMPTY) &&
           (addr >= cfg.addr_start) &&
           (addr < cfg.addr_end);
  endfunction

endpackage

// File: rtl/pnp_addr_lookup.sv
// pnp_addr_lookup: resolves a 64-bit bus address to the lowest-index slave
// descriptor whose window contains it. Sequential scan, one slot per cycle,
// with a one-entry last-hit cache for single-cycle repeat lookups.
// Ports:
//   i_clk, i_nrst      clock, asynchronous active-low reset
//   i_cfg              live descriptor vector
//   i_req_valid/addr   request, accepted when o_req_ready is high
//   o_req_ready        high in IDLE only
//   o_resp_*           response (hit, idx, vid, did), held until i_resp_ready
//   o_busy             high while scanning or holding a response
module pnp_addr_lookup
  import types_pnp_pkg::*;
#(
  parameter bit CACHE_EN = 1'b1
) (
  input  logic                        i_clk,
  input  logic                        i_nrst,
  input  soc_pnp_vector               i_cfg,
  input  logic                        i_req_valid,
  input  logic [63:0]                 i_req_addr,
  output logic                        o_req_ready,
  output logic                        o_resp_valid,
  output logic                        o_resp_hit,
  output logic [SOC_PNP_IDX_BITS-1:0] o_resp_idx,
  output logic [15:0]                 o_resp_vid,
  output logic [15:0]                 o_resp_did,
  input  logic                        i_resp_ready,
  output logic                        o_busy
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    SCAN = 2'b01,
    RESP = 2'b10
  } state_e;

  localparam logic [SOC_PNP_IDX_BITS-1:0] LAST_IDX = SOC_PNP_IDX_BITS'(SOC_PNP_TOTAL - 1);

  state_e                      state_q, state_d;
  logic [63:0]                 addr_q, addr_d;
  logic [SOC_PNP_IDX_BITS-1:0] idx_q, idx_d;
  logic                        hit_q, hit_d;
  logic [SOC_PNP_IDX_BITS-1:0] ridx_q, ridx_d;
  logic [15:0]                 vid_q, vid_d;
  logic [15:0]                 did_q, did_d;
  logic                        cache_valid_q, cache_valid_d;
  logic [SOC_PNP_IDX_BITS-1:0] cache_idx_q, cache_idx_d;

  dev_config_type scan_cfg;
  dev_config_type cache_cfg;
  logic           cache_hit;

  always_comb begin
    scan_cfg  = i_cfg[idx_q];
    cache_cfg = i_cfg[cache_idx_q];
    // The cached slot is re-qualified against the live descriptor, so a
    // reconfigured slot simply stops hitting and the request falls back to
    // a scan.
    cache_hit = CACHE_EN && cache_valid_q && pnp_addr_match(cache_cfg, i_req_addr);
  end

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    idx_d         = idx_q;
    hit_d         = hit_q;
    ridx_d        = ridx_q;
    vid_d         = vid_q;
    did_d         = did_q;
    cache_valid_d = cache_valid_q;
    cache_idx_d   = cache_idx_q;

    unique case (state_q)
      IDLE: begin
        if (i_req_valid) begin
          addr_d = i_req_addr;
          if (cache_hit) begin
            hit_d   = 1'b1;
            ridx_d  = cache_idx_q;
            vid_d   = cache_cfg.vid;
            did_d   = cache_cfg.did;
            state_d = RESP;
          end else begin
            idx_d   = '0;
            state_d = SCAN;
          end
        end
      end

      SCAN: begin
        if (pnp_addr_match(scan_cfg, addr_q)) begin
          hit_d         = 1'b1;
          ridx_d        = idx_q;
          vid_d         = scan_cfg.vid;
          did_d         = scan_cfg.did;
          cache_valid_d = CACHE_EN;
          cache_idx_d   = idx_q;
          state_d       = RESP;
        end else if (idx_q == LAST_IDX) begin
          // Miss: the cache keeps whatever it last learned.
          hit_d   = 1'b0;
          ridx_d  = '0;
          vid_d   = '0;
          did_d   = '0;
          state_d = RESP;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end

      RESP: begin
        if (i_resp_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state_q       <= IDLE;
      addr_q        <= '0;
      idx_q         <= '0;
      hit_q         <= 1'b0;
      ridx_q        <= '0;
      vid_q         <= '0;
      did_q         <= '0;
      cache_valid_q <= 1'b0;
      cache_idx_q   <= '0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      idx_q         <= idx_d;
      hit_q         <= hit_d;
      ridx_q        <= ridx_d;
      vid_q         <= vid_d;
      did_q         <= did_d;
      cache_valid_q <= cache_valid_d;
      cache_idx_q   <= cache_idx_d;
    end
  end

  // Gated by i_nrst so ready is low for the whole reset, not just after it.
  assign o_req_ready  = (state_q == IDLE) && i_nrst;
  assign o_resp_valid = (state_q == RESP);
  assign o_busy       = (state_q != IDLE);
  assign o_resp_hit   = hit_q;
  assign o_resp_idx   = ridx_q;
  assign o_resp_vid   = vid_q;
  assign o_resp_did   = did_q;

endmodule

// File: tb/tb_pnp_addr_lookup.sv
// tb_pnp_addr_lookup: directed checks of the address lookup engine:
// reset state, scan/cache latency, miss, priority, skipped slots, window
// boundaries, cache coherence with live config, back-pressure, back-to-back
// cache hits and reset in the middle of a scan.
module tb_pnp_addr_lookup;
  import types_pnp_pkg::*;

  logic          clk;
  logic          nrst;
  soc_pnp_vector cfg;
  logic          req_valid;
  logic [63:0]   req_addr;
  logic          req_ready;
  logic          resp_valid;
  logic          resp_hit;
  logic [3:0]    resp_idx;
  logic [15:0]   resp_vid;
  logic [15:0]   resp_did;
  logic          resp_ready;
  logic          busy;

  int tests_run    = 0;
  int tests_failed = 0;

  pnp_addr_lookup #(.CACHE_EN(1'b1)) dut (
    .i_clk        (clk),
    .i_nrst       (nrst),
    .i_cfg        (cfg),
    .i_req_valid  (req_valid),
    .i_req_addr   (req_addr),
    .o_req_ready  (req_ready),
    .o_resp_valid (resp_valid),
    .o_resp_hit   (resp_hit),
    .o_resp_idx   (resp_idx),
    .o_resp_vid   (resp_vid),
    .o_resp_did   (resp_did),
    .i_resp_ready (resp_ready),
    .o_busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one request from IDLE, measure latency in cycles after the
  // handshake, capture the response and consume it one cycle later.
  task automatic do_req(input logic [63:0] addr, output int lat,
                        output logic [36:0] fields);
    @(posedge clk); #1;
    req_valid = 1'b1;
    req_addr  = addr;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!resp_valid && lat < 40);
    if (!resp_valid) lat = -1;
    fields = {resp_hit, resp_idx, resp_vid, resp_did};
    $display("[TB] req addr=%h lat=%0d hit=%0d idx=%0d vid=%h did=%h",
             addr, lat, resp_hit, resp_idx, resp_vid, resp_did);
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
  endtask

  task automatic set_slot(input int k, input pnp_cfg_type_e t, input logic [63:0] s,
                          input logic [63:0] e, input logic [15:0] vid, input logic [15:0] did);
    cfg[k].descrtype  = t;
    cfg[k].addr_start = s;
    cfg[k].addr_end   = e;
    cfg[k].vid        = vid;
    cfg[k].did        = did;
  endtask

  task automatic test_reset;
    #12;
    tests_run++;
    if ({resp_valid, resp_hit, resp_idx, resp_vid, resp_did, busy, req_ready} !== 40'd0) begin
      tests_failed++;
      $display("FAIL reset_outputs got=%h want=0",
               {resp_valid, resp_hit, resp_idx, resp_vid, resp_did, busy, req_ready});
    end
    @(posedge clk); #1;
    nrst = 1'b1;
    @(negedge clk);
    tests_run++;
    if ({req_ready, busy, resp_valid} !== 3'b100) begin
      tests_failed++;
      $display("FAIL reset_release got=%b want=100", {req_ready, busy, resp_valid});
    end
  endtask

  task automatic test_scan_and_cache;
    int lat; logic [36:0] f;
    do_req(64'h10, lat, f);
    tests_run++;
    if (lat !== 4) begin tests_failed++; $display("FAIL scan_slot2_lat got=%0d want=4", lat); end
    tests_run++;
    if (f !== {1'b1, 4'd2, 16'h00F2, 16'h0071}) begin
      tests_failed++; $display("FAIL scan_slot2_fields got=%h want=%h", f, {1'b1, 4'd2, 16'h00F2, 16'h0071});
    end
    do_req(64'h20, lat, f);
    tests_run++;
    if (lat !== 1) begin tests_failed++; $display("FAIL cache_hit_lat got=%0d want=1", lat); end
    tests_run++;
    if (f !== {1'b1, 4'd2, 16'h00F2, 16'h0071}) begin
      tests_failed++; $display("FAIL cache_hit_fields got=%h want=%h", f, {1'b1, 4'd2, 16'h00F2, 16'h0071});
    end
  endtask

  task automatic test_miss;
    int lat; logic [36:0] f;
    do_req(64'hFFFF_0000_0000_0000, lat, f);
    tests_run++;
    if (lat !== 17) begin tests_failed++; $display("FAIL miss_lat got=%0d want=17", lat); end
    tests_run++;
    if (f !== 37'd0) begin tests_failed++; $display("FAIL miss_fields got=%h want=0", f); end
    do_req(64'h30, lat, f);
    tests_run++;
    if (lat !== 1) begin tests_failed++; $display("FAIL miss_keeps_cache_lat got=%0d want=1", lat); end
  endtask

  task automatic test_priority;
    int lat; logic [36:0] f;
    do_req(64'h0200_0000, lat, f);
    tests_run++;
    if (lat !== 7) begin tests_failed++; $display("FAIL prio_lat got=%0d want=7", lat); end
    tests_run++;
    if (f !== {1'b1, 4'd5, 16'h00F3, 16'h0080}) begin
      tests_failed++; $display("FAIL prio_fields got=%h want=%h", f, {1'b1, 4'd5, 16'h00F3, 16'h0080});
    end
    do_req(64'h0350_0000, lat, f);
    tests_run++;
    if (lat !== 11 || f !== {1'b1, 4'd9, 16'h00F4, 16'h0090}) begin
      tests_failed++; $display("FAIL slot9_only got lat=%0d f=%h want lat=11 f=%h", lat, f, {1'b1, 4'd9, 16'h00F4, 16'h0090});
    end
  endtask

  task automatic test_coherence;
    int lat; logic [36:0] f;
    do_req(64'h10, lat, f);
    tests_run++;
    if (lat !== 4) begin tests_failed++; $display("FAIL recache_slot2_lat got=%0d want=4", lat); end
    cfg[2].addr_end = 64'h8;
    do_req(64'h10, lat, f);
    tests_run++;
    if (lat !== 14) begin tests_failed++; $display("FAIL coherence_lat got=%0d want=14", lat); end
    tests_run++;
    if (f !== {1'b1, 4'd12, 16'h00F1, 16'h0072}) begin
      tests_failed++; $display("FAIL coherence_fields got=%h want=%h", f, {1'b1, 4'd12, 16'h00F1, 16'h0072});
    end
    cfg[2].addr_end = 64'h0004_0000;
  endtask

  task automatic test_boundaries;
    int lat; logic [36:0] f;
    do_req(64'h03FF_FFFF, lat, f);
    tests_run++;
    if (lat !== 11 || f !== {1'b1, 4'd9, 16'h00F4, 16'h0090}) begin
      tests_failed++; $display("FAIL end_minus_one got lat=%0d f=%h want lat=11 f=%h", lat, f, {1'b1, 4'd9, 16'h00F4, 16'h0090});
    end
    do_req(64'h0400_0000, lat, f);
    tests_run++;
    if (lat !== 17 || f !== 37'd0) begin
      tests_failed++; $display("FAIL end_exclusive got lat=%0d f=%h want lat=17 f=0", lat, f);
    end
    do_req(64'h5800_0000, lat, f);
    tests_run++;
    if (lat !== 17 || f !== 37'd0) begin
      tests_failed++; $display("FAIL inverted_window got lat=%0d f=%h want lat=17 f=0", lat, f);
    end
  endtask

  task automatic test_backpressure;
    int lat; logic [36:0] f; logic [36:0] seen; int bad;
    @(posedge clk); #1;
    req_valid = 1'b1;
    req_addr  = 64'h2000;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!resp_valid && lat < 40);
    f = {resp_hit, resp_idx, resp_vid, resp_did};
    $display("[TB] req addr=%h lat=%0d hit=%0d idx=%0d (held)", 64'h2000, lat, resp_hit, resp_idx);
    tests_run++;
    if (lat !== 4 || f !== {1'b1, 4'd2, 16'h00F2, 16'h0071}) begin
      tests_failed++; $display("FAIL bp_first got lat=%0d f=%h want lat=4 f=%h", lat, f, {1'b1, 4'd2, 16'h00F2, 16'h0071});
    end
    bad = 0;
    seen = f;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!resp_valid || req_ready || {resp_hit, resp_idx, resp_vid, resp_did} !== f) begin
        bad++;
        seen = {resp_hit, resp_idx, resp_vid, resp_did};
      end
    end
    tests_run++;
    if (bad !== 0) begin
      tests_failed++; $display("FAIL bp_hold bad_cycles=%0d last=%h want 0 bad, f=%h", bad, seen, f);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    @(negedge clk);
    tests_run++;
    if ({req_ready, resp_valid} !== 2'b10) begin
      tests_failed++; $display("FAIL bp_release got=%b want=10", {req_ready, resp_valid});
    end
  endtask

  task automatic test_back_to_back;
    logic [4:0] obs [4];
    // Slot 2 is cached; two requests back to back with resp_ready high.
    @(posedge clk); #1;
    req_valid  = 1'b1;
    req_addr   = 64'h100;
    resp_ready = 1'b1;
    @(posedge clk); #1;           // first handshake
    @(negedge clk); obs[0] = {resp_valid, req_ready, resp_idx[2:0]};
    @(negedge clk); obs[1] = {resp_valid, req_ready, resp_idx[2:0]};
    @(posedge clk); #1;           // second handshake
    req_valid = 1'b0;
    @(negedge clk); obs[2] = {resp_valid, req_ready, resp_idx[2:0]};
    @(negedge clk); obs[3] = {resp_valid, req_ready, resp_idx[2:0]};
    resp_ready = 1'b0;
    $display("[TB] back-to-back addr=%h x2 cycles: %b %b %b %b", 64'h100, obs[0], obs[1], obs[2], obs[3]);
    tests_run++;
    if (obs[0] !== 5'b10010) begin tests_failed++; $display("FAIL b2b_resp1 got=%b want=10010", obs[0]); end
    tests_run++;
    if (obs[1] !== 5'b01010) begin tests_failed++; $display("FAIL b2b_gap got=%b want=01010", obs[1]); end
    tests_run++;
    if (obs[2] !== 5'b10010) begin tests_failed++; $display("FAIL b2b_resp2 got=%b want=10010", obs[2]); end
    tests_run++;
    if (obs[3] !== 5'b01010) begin tests_failed++; $display("FAIL b2b_idle got=%b want=01010", obs[3]); end
  endtask

  task automatic test_reset_midscan;
    int lat; logic [36:0] f; logic b;
    @(posedge clk); #1;
    req_valid = 1'b1;
    req_addr  = 64'hFFFF_0000_0000_0000;
    @(posedge clk); #1;           // handshake, scan starts at slot 0
    req_valid = 1'b0;
    repeat (7) @(posedge clk);    // now examining slot 7
    #2;
    b = busy;
    nrst = 1'b0;
    #1;
    $display("[TB] reset asserted mid-scan busy_before=%0d", b);
    tests_run++;
    if (b !== 1'b1) begin tests_failed++; $display("FAIL midscan_busy got=%0d want=1", b); end
    tests_run++;
    if ({resp_valid, resp_hit, resp_idx, resp_vid, resp_did, busy, req_ready} !== 40'd0) begin
      tests_failed++;
      $display("FAIL midscan_reset_outputs got=%h want=0",
               {resp_valid, resp_hit, resp_idx, resp_vid, resp_did, busy, req_ready});
    end
    repeat (2) @(posedge clk);
    #1;
    nrst = 1'b1;
    do_req(64'h2000, lat, f);
    tests_run++;
    if (lat !== 4 || f !== {1'b1, 4'd2, 16'h00F2, 16'h0071}) begin
      tests_failed++; $display("FAIL cache_cleared got lat=%0d f=%h want lat=4 f=%h", lat, f, {1'b1, 4'd2, 16'h00F2, 16'h0071});
    end
  endtask

  initial begin
    nrst       = 1'b0;
    req_valid  = 1'b0;
    req_addr   = '0;
    resp_ready = 1'b0;
    for (int k = 0; k < SOC_PNP_TOTAL; k++)
      set_slot(k, PNP_CFG_TYPE_INVALID, 64'h0, 64'h0, 16'h0, SLV_DID_EMPTY);
    set_slot(2,  PNP_CFG_TYPE_SLAVE,  64'h0,          64'h0004_0000, 16'h00F2, 16'h0071);
    set_slot(3,  PNP_CFG_TYPE_SLAVE,  64'h0200_0000,  64'h0210_0000, 16'h00F2, SLV_DID_EMPTY);
    set_slot(4,  PNP_CFG_TYPE_MASTER, 64'h0200_0000,  64'h0210_0000, 16'h00F2, 16'h0050);
    set_slot(5,  PNP_CFG_TYPE_SLAVE,  64'h0200_0000,  64'h0300_0000, 16'h00F3, 16'h0080);
    set_slot(7,  PNP_CFG_TYPE_SLAVE,  64'h6000_0000,  64'h5000_0000, 16'h00F5, 16'h00A0);
    set_slot(9,  PNP_CFG_TYPE_SLAVE,  64'h0100_0000,  64'h0400_0000, 16'h00F4, 16'h0090);
    set_slot(12, PNP_CFG_TYPE_SLAVE,  64'h0,          64'h0000_1000, 16'h00F1, 16'h0072);

    test_reset;
    test_scan_and_cache;
    test_miss;
    test_priority;
    test_coherence;
    test_boundaries;
    test_backpressure;
    test_back_to_back;
    test_reset_midscan;

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/pnp_addr_lookup.md
# pnp_addr_lookup

Sequential address-to-slot lookup engine over the plug-and-play descriptor vector (`soc_pnp_vector`). Given a 64-bit bus address, it finds the lowest-index slave descriptor whose range contains the address. It returns the slot index and the descriptor's VID/DID through valid/ready handshakes. A one-entry last-hit cache gives single-cycle answers for repeated accesses. It sits beside the pnp slave and is used by the interconnect error/debug path and the DMI/SBA bridge to resolve addresses to devices.

## Interface
Parameters:
- CACHE_EN, default 1: enables the last-hit cache. 0 forces every lookup to scan.

Ports:
- i_clk  in  1  system clock; the single clock domain.
- i_nrst  in  1  reset, asynchronous assert, active-low.
- i_cfg  in  soc_pnp_vector  live descriptor vector, SOC_PNP_TOTAL entries.
- i_req_valid  in  1  lookup request valid.
- i_req_addr  in  64  address to resolve.
- o_req_ready  out  1  request accepted when high with i_req_valid.
- o_resp_valid  out  1  response valid.
- o_resp_hit  out  1  1 = matching slave found.
- o_resp_idx  out  4  matching slot index; 0 on miss.
- o_resp_vid  out  16  VID of the match; 0 on miss.
- o_resp_did  out  16  DID of the match; 0 on miss.
- i_resp_ready  in  1  response consumed when high with o_resp_valid.
- o_busy  out  1  high in the SCAN or RESP state.

## Operation
- Match rule for slot k:
  - i_cfg[k].descrtype == PNP_CFG_TYPE_SLAVE,
  - i_cfg[k].did != SLV_DID_EMPTY,
  - addr_start <= addr < addr_end, unsigned 64-bit compares (end is exclusive).
  - If addr_end <= addr_start, the slot never matches.
- Overlapping ranges: the lowest index wins.
- States:
  - IDLE: o_req_ready=1. On handshake, latch the address into r_addr.
    - Cache hit → RESP.
    - Otherwise clear the scan counter to 0 → SCAN.
  - SCAN: examine slot r_idx once per cycle.
    - Match → latch idx/vid/did, set hit=1, update the cache → RESP.
    - r_idx==SOC_PNP_TOTAL-1 with no match → latch hit=0, idx/vid/did=0 → RESP.
    - Otherwise increment r_idx.
  - RESP: o_resp_valid=1 with stable fields. When i_resp_ready=1 → IDLE.
- Cache:
  - Holds a valid bit and an index.
  - Hit when the valid bit is set and slot[cache_idx] satisfies the full match rule against *live* i_cfg. This keeps it coherent with config changes without a flush.
  - Lowest-index priority is preserved only when no lower slot overlaps. An overlap that makes a lower slot match is not detected on a cache hit. Overlapping slave ranges are a config error and are documented as such.
  - The cache is written only by a successful scan. A miss leaves it unchanged.
- VID/DID for a cache hit are read from live i_cfg[cache_idx] at request-accept time and then registered.
- Outputs do not depend on i_cfg changes after the relevant capture cycle.
- Reset at any time, including mid-scan or mid-response:
  - state=IDLE, cache invalid, all outputs 0 except o_req_ready=1 once out of reset.
  - Any pending response is dropped.

## Timing
- Request handshake in cycle 0.
- Cache hit: o_resp_valid rises in cycle 1 (latency 1).
- Scan hit at slot k: slot k is examined in cycle k+1; o_resp_valid rises in cycle k+2.
- Scan miss: o_resp_valid rises in cycle SOC_PNP_TOTAL+1 = 17.
- The response is held, with no field changes, until i_resp_ready. If i_resp_ready is already high, the response lasts 1 cycle.
- o_req_ready is combinational from state==IDLE; no request is accepted in SCAN or RESP.
- Next request: it can be accepted in the cycle after the response handshake, so the minimum back-to-back period is 2 cycles for cache hits.
- Reset values:
  - o_resp_valid=0, o_resp_hit=0, o_resp_idx=0, o_resp_vid=0, o_resp_did=0, o_busy=0.
  - o_req_ready=0 while i_nrst=0 and 1 after release.

## Structure
- Add function pnp_addr_match(dev_config_type cfg, logic [63:0] addr) to types_pnp_pkg. It is reused by the interconnect decoder.
- Add localparam int SOC_PNP_IDX_BITS = $clog2(SOC_PNP_TOTAL) to types_pnp_pkg.
- The state enum is local to the module.
- No sub-module is needed. The range compare is the package function, and the scan mux is inline.

## Test plan
- Slot 2 = ROM [0x0000_0000, 0x0004_0000), request 0x10 → resp in cycle 4: hit=1, idx=2, did=0x0071, vid=0x00F2. A repeat request to 0x20 → resp in cycle 1, same fields.
- Address 0xFFFF_0000_0000_0000 matching no slot → resp in cycle 17: hit=0, idx=0, vid=0, did=0. The cache is unchanged, and a following cached-slot request still answers in 1 cycle.
- Slots 5 and 9 both cover 0x0200_0000 → idx=5. A slot with did=SLV_DID_EMPTY or type MASTER covering the address is skipped.
- After caching slot 2, change i_cfg[2].addr_end to 0x8 and request 0x10 → no cache hit, full scan. Result is a miss, or the next matching slot.
- i_resp_ready held low 10 cycles → the response stays stable and o_req_ready=0. Then assert i_resp_ready → o_req_ready=1 in the next cycle.
- Assert i_nrst=0 during SCAN at r_idx=7 → outputs zero immediately. After release, the cache is invalid: a prior cached address scans again (latency k+2).
